xbar_rr_switch: RTL and testbench
=================================

XBAR_RR_SWITCH -- requirements
Module: xbar_rr_switch

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of input and output ports (W, E, N, S, PE order for 5); legal range 2..8.
REQ-002 Parameter FLIT_SIZE, default 16, flit data width in bits.
REQ-003 Derived DEST_W = clog2(NUM_PORTS), width of one destination index.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  NUM_PORTS  per-input flit valid.
REQ-007 in_data  input  NUM_PORTS*FLIT_SIZE  per-input flit data; input i occupies bits [i*FLIT_SIZE +: FLIT_SIZE].
REQ-008 in_dest  input  NUM_PORTS*DEST_W  per-input destination output index; sampled only on a head flit.
REQ-009 in_tail  input  NUM_PORTS  per-input tail marker; 1 = last flit of packet (single-flit packet = head and tail).
REQ-010 in_ready  output  NUM_PORTS  per-input combinational accept; a flit transfers when in_valid & in_ready.
REQ-011 out_valid  output  NUM_PORTS  per-output registered valid.
REQ-012 out_data  output  NUM_PORTS*FLIT_SIZE  per-output registered flit.
REQ-013 out_ready  input  NUM_PORTS  per-output downstream accept.
REQ-014 sw_done  output  NUM_PORTS  per-input registered 1-cycle pulse, cycle after that input's tail flit is accepted.
REQ-015 dest_err  output  NUM_PORTS  per-input registered 1-cycle pulse, cycle after a head with in_dest >= NUM_PORTS is discarded.

Function
REQ-016 Each output o SHALL own: a 1-entry output register (out_valid/out_data), a lock flag, an owner index, and a round-robin pointer rr_ptr.
REQ-017 Output register o SHALL be able to load when out_valid[o]==0 or out_ready[o]==1 in the same cycle ("space").
REQ-018 Unlocked output: requesters are inputs with in_valid=1, not already holding another output lock, and in_dest==o; the grant SHALL go to the first requester at or after rr_ptr, scanning upward with wrap-around modulo NUM_PORTS.
REQ-019 Grant SHALL only be given when output o has space; in_ready[i]=1 only for the granted input.
REQ-020 On an accepted head flit with in_tail=0, output o SHALL lock to owner i; subsequent flits of input i bypass arbitration and in_dest is ignored.
REQ-021 Locked output: in_ready[owner] = in_valid[owner] & space; all other inputs see in_ready=0 for that output.
REQ-022 On acceptance of a tail flit (single- or multi-flit packet), lock SHALL clear and rr_ptr SHALL become (owner+1) mod NUM_PORTS; rr_ptr SHALL NOT change otherwise.
REQ-023 Accepted flit SHALL appear on out_data[o] with out_valid[o]=1 exactly one cycle after acceptance (latency 1).
REQ-024 out_valid[o] SHALL fall after out_ready[o]=1 when no new flit loads that cycle; out_data holds while out_valid=1 and out_ready=0.
REQ-025 Different outputs SHALL transfer concurrently; up to NUM_PORTS flits per cycle.
REQ-026 A head flit with in_dest >= NUM_PORTS SHALL be accepted (in_ready=1), discarded, and raise dest_err[i] next cycle; no lock taken.
REQ-027 Zero-cycle lock to release: tail accepted and new head grant to the same output SHALL NOT occur in the same cycle; the new grant occurs earliest the next cycle.
REQ-028 in_valid falling mid-packet SHALL keep the lock held (bubble), no flit transferred.

Reset
REQ-029 While RST=0: out_valid=0, out_data=0, sw_done=0, dest_err=0, all locks clear, all rr_ptr=0, all owners=0; in_ready=0.
REQ-030 Reset assertion mid-packet SHALL abort the packet immediately; no partial state survives deassertion.
REQ-031 First grant after reset deassertion SHALL be possible on the first rising edge with RST=1.

Verification
REQ-032 Single-flit: in0 head+tail data 16'hA5A5 dest 1, out_ready=1 -> out_valid[1]=1, out_data[1]=16'hA5A5 next cycle, sw_done[0] pulse same cycle.
REQ-033 Contention: inputs 0,2,3 all send single-flit packets to dest 4 continuously -> grant order 0,2,3,0 from reset with one flit on output 4 per cycle.
REQ-034 Wormhole: in1 sends 3-flit packet to dest 0 while in2 requests dest 0 -> in2 in_ready=0 until cycle after in1 tail accepted; no interleaving on output 0.
REQ-035 Backpressure: out_ready[2]=0 for 4 cycles with flit 16'h1234 held -> out_data[2] stable, owner in_ready=0; flit 2 accepted on the cycle out_ready rises.
REQ-036 Parallel and error: in0->3, in3->0 same cycle both delivered next cycle; in4 head dest 7 (NUM_PORTS=5) -> dest_err[4] pulse, no out_valid anywhere.
REQ-037 Reset mid-packet: RST=0 after 2 of 4 flits -> all out_valid=0, locks clear; new packet from another input to that output granted after release.

Source files
------------

// File: rtl/xbar_rr_switch.sv
// Wormhole crossbar: every output owns a round-robin arbiter, a packet lock
// and a one-entry output register, so independent outputs move flits in parallel.
module xbar_rr_switch #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_SIZE = 16,
    localparam int DEST_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS*FLIT_SIZE-1:0] in_data,
    input  logic [NUM_PORTS*DEST_W-1:0]    in_dest,
    input  logic [NUM_PORTS-1:0]           in_tail,
    output logic [NUM_PORTS-1:0]           in_ready,
    output logic [NUM_PORTS-1:0]           out_valid,
    output logic [NUM_PORTS*FLIT_SIZE-1:0] out_data,
    input  logic [NUM_PORTS-1:0]           out_ready,
    output logic [NUM_PORTS-1:0]           sw_done,
    output logic [NUM_PORTS-1:0]           dest_err
);
    localparam logic [DEST_W:0] PORTS = (DEST_W+1)'(NUM_PORTS);

    logic [DEST_W-1:0]    dest    [NUM_PORTS];
    logic [FLIT_SIZE-1:0] data    [NUM_PORTS];
    logic [DEST_W-1:0]    owner   [NUM_PORTS];
    logic [DEST_W-1:0]    rr_ptr  [NUM_PORTS];
    logic [DEST_W-1:0]    sel     [NUM_PORTS];
    logic [FLIT_SIZE-1:0] out_reg [NUM_PORTS];
    logic [NUM_PORTS-1:0] lock;
    logic [NUM_PORTS-1:0] space;
    logic [NUM_PORTS-1:0] gnt;
    logic [NUM_PORTS-1:0] holding;
    logic [NUM_PORTS-1:0] bad_dest;
    logic [NUM_PORTS-1:0] ready;
    logic [NUM_PORTS-1:0] tail_hit;

    function automatic logic [DEST_W-1:0] ptr_after(input logic [DEST_W-1:0] idx);
        logic [DEST_W:0] nxt;
        nxt = {1'b0, idx} + 1'b1;
        ptr_after = (nxt == PORTS) ? '0 : nxt[DEST_W-1:0];
    endfunction

    always_comb begin
        logic                found;
        logic [DEST_W-1:0]   idx;
        found    = 1'b0;
        idx      = '0;
        holding  = '0;
        ready    = '0;
        tail_hit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest[i] = in_dest[i*DEST_W +: DEST_W];
            data[i] = in_data[i*FLIT_SIZE +: FLIT_SIZE];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (lock[o]) holding[owner[o]] = 1'b1;
        end
        // An input already owning an output is mid-packet; its in_dest is don't-care.
        for (int i = 0; i < NUM_PORTS; i++) begin
            bad_dest[i] = in_valid[i] & ~holding[i] & ({1'b0, dest[i]} >= PORTS);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            space[o] = ~out_valid[o] | out_ready[o];
            sel[o]   = owner[o];
            gnt[o]   = 1'b0;
            found    = 1'b0;
            idx      = rr_ptr[o];
            if (lock[o]) begin
                gnt[o] = in_valid[owner[o]] & space[o];
            end else if (space[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (!found && in_valid[idx] && !holding[idx] && dest[idx] == DEST_W'(o)) begin
                        found  = 1'b1;
                        sel[o] = idx;
                    end
                    idx = ptr_after(idx);
                end
                gnt[o] = found;
            end
        end
        ready = bad_dest;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt[o]) begin
                ready[sel[o]] = 1'b1;
                if (in_tail[sel[o]]) tail_hit[sel[o]] = 1'b1;
            end
        end
        in_ready = RST ? ready : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lock      <= '0;
            out_valid <= '0;
            sw_done   <= '0;
            dest_err  <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                owner[o]   <= '0;
                rr_ptr[o]  <= '0;
                out_reg[o] <= '0;
            end
        end else begin
            sw_done  <= tail_hit;
            dest_err <= bad_dest;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (gnt[o]) begin
                    out_valid[o] <= 1'b1;
                    out_reg[o]   <= data[sel[o]];
                    owner[o]     <= sel[o];
                    // Pointer only advances when a packet completes.
                    if (in_tail[sel[o]]) begin
                        lock[o]   <= 1'b0;
                        rr_ptr[o] <= ptr_after(sel[o]);
                    end else begin
                        lock[o]   <= 1'b1;
                    end
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        assign out_data[o*FLIT_SIZE +: FLIT_SIZE] = out_reg[o];
    end

endmodule

// File: tb/tb_xbar_rr_switch.sv
// Self-checking bench for xbar_rr_switch: directed scenarios plus randomized
// traffic compared every cycle against a behavioural switch model.
`timescale 1ns/1ps
module tb_xbar_rr_switch;
    localparam int N  = 5;
    localparam int F  = 16;
    localparam int DW = 3;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*F-1:0] in_data  = '0;
    logic [N*DW-1:0] in_dest = '0;
    logic [N-1:0]   in_tail  = '0;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   out_valid;
    logic [N*F-1:0] out_data;
    logic [N-1:0]   out_ready = '1;
    logic [N-1:0]   sw_done;
    logic [N-1:0]   dest_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    xbar_rr_switch #(.NUM_PORTS(N), .FLIT_SIZE(F)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_tail(in_tail),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sw_done(sw_done), .dest_err(dest_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Behavioural model: packets hold an output until their tail; free outputs
    // pick the requester nearest (cyclically) to the pointer.
    logic         m_lock  [N];
    int           m_owner [N];
    int           m_ptr   [N];
    int           m_gnt   [N];
    logic [F-1:0] m_od    [N];
    logic [N-1:0] m_ov, m_sw, m_de, m_rdy, m_hold;

    function automatic int dest_of(input int i);
        return int'(in_dest[i*DW +: DW]);
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_lock[o] = 1'b0; m_owner[o] = 0; m_ptr[o] = 0; m_od[o] = '0; m_gnt[o] = -1;
        end
        m_ov = '0; m_sw = '0; m_de = '0;
    endtask

    task automatic model_comb();
        int  bestd, d;
        bit  sp;
        m_hold = '0;
        for (int o = 0; o < N; o++) if (m_lock[o]) m_hold[m_owner[o]] = 1'b1;
        m_rdy = '0;
        for (int o = 0; o < N; o++) begin
            m_gnt[o] = -1;
            sp = !m_ov[o] || out_ready[o];
            if (sp && m_lock[o]) begin
                if (in_valid[m_owner[o]]) m_gnt[o] = m_owner[o];
            end else if (sp) begin
                bestd = N;
                for (int i = 0; i < N; i++) begin
                    if (in_valid[i] && !m_hold[i] && dest_of(i) == o) begin
                        d = (i - m_ptr[o] + N) % N;
                        if (d < bestd) begin bestd = d; m_gnt[o] = i; end
                    end
                end
            end
            if (m_gnt[o] >= 0) m_rdy[m_gnt[o]] = 1'b1;
        end
        for (int i = 0; i < N; i++)
            if (in_valid[i] && !m_hold[i] && dest_of(i) >= N) m_rdy[i] = 1'b1;
        if (!RST) m_rdy = '0;
    endtask

    task automatic model_clock();
        int g;
        m_sw = '0; m_de = '0;
        for (int i = 0; i < N; i++)
            if (in_valid[i] && !m_hold[i] && dest_of(i) >= N) m_de[i] = 1'b1;
        for (int o = 0; o < N; o++) begin
            if (m_gnt[o] >= 0) begin
                g = m_gnt[o];
                m_ov[o] = 1'b1; m_od[o] = in_data[g*F +: F]; m_owner[o] = g;
                if (in_tail[g]) begin
                    m_lock[o] = 1'b0; m_ptr[o] = (g + 1) % N; m_sw[g] = 1'b1;
                end else begin
                    m_lock[o] = 1'b1;
                end
            end else if (out_ready[o]) begin
                m_ov[o] = 1'b0;
            end
        end
    endtask

    task automatic pre();
        #1;
        model_comb();
        total_cnt++;
        if (in_ready !== m_rdy) $display("FAIL model_in_ready t=%0t got=%b exp=%b", $time, in_ready, m_rdy);
        else pass_cnt++;
    endtask

    task automatic post();
        logic [N*F-1:0] exp_od;
        @(posedge CLK);
        model_clock();
        #1;
        for (int o = 0; o < N; o++) exp_od[o*F +: F] = m_od[o];
        total_cnt++;
        if (out_valid !== m_ov) $display("FAIL model_out_valid t=%0t got=%b exp=%b", $time, out_valid, m_ov);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== exp_od) $display("FAIL model_out_data t=%0t got=%h exp=%h", $time, out_data, exp_od);
        else pass_cnt++;
        total_cnt++;
        if (sw_done !== m_sw) $display("FAIL model_sw_done t=%0t got=%b exp=%b", $time, sw_done, m_sw);
        else pass_cnt++;
        total_cnt++;
        if (dest_err !== m_de) $display("FAIL model_dest_err t=%0t got=%b exp=%b", $time, dest_err, m_de);
        else pass_cnt++;
    endtask

    task automatic set_in(input int i, input logic v, input logic [F-1:0] d, input int dst, input logic t);
        in_valid[i] = v;
        in_data[i*F +: F] = d;
        in_dest[i*DW +: DW] = DW'(dst);
        in_tail[i] = t;
    endtask

    task automatic clear_in();
        in_valid = '0; in_data = '0; in_dest = '0; in_tail = '0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        clear_in();
        out_ready = '1;
        RST = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        RST = 1'b0;
        in_valid = '1; in_tail = '1; in_data = {N{16'hFFFF}}; out_ready = '0;
        #1;
        total_cnt++;
        if (in_ready !== '0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else pass_cnt++;
        total_cnt++;
        if (out_valid !== '0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++;
        if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else pass_cnt++;
        @(posedge CLK);
        #1;
        total_cnt++;
        if ({sw_done, dest_err, out_valid} !== '0)
            $display("FAIL reset_pulses got=%b exp=0", {sw_done, dest_err, out_valid});
        else pass_cnt++;
        clear_in();
        out_ready = '1;
        RST = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        set_in(0, 1'b1, 16'hA5A5, 1, 1'b1);
        pre();
        total_cnt++;
        if (in_ready[0] !== 1'b1) $display("FAIL single_ready got=%b exp=1", in_ready[0]); else pass_cnt++;
        post();
        total_cnt++;
        if (out_valid[1] !== 1'b1 || out_data[F +: F] !== 16'hA5A5)
            $display("FAIL single_out got=%b/%h exp=1/a5a5", out_valid[1], out_data[F +: F]);
        else pass_cnt++;
        total_cnt++;
        if (sw_done !== 5'b00001) $display("FAIL single_sw_done got=%b exp=00001", sw_done); else pass_cnt++;
        clear_in();
        pre();
        post();
        total_cnt++;
        if (out_valid[1] !== 1'b0 || sw_done !== '0)
            $display("FAIL single_drain got=%b/%b exp=0/0", out_valid[1], sw_done);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        int           ord [4] = '{0, 2, 3, 0};
        logic [N-1:0] one;
        logic [F-1:0] e;
        do_reset();
        for (int i = 0; i < N; i++)
            if (i == 0 || i == 2 || i == 3) set_in(i, 1'b1, F'(16'h1000 + i), 4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            one = N'(1) << ord[k];
            e   = F'(16'h1000 + ord[k]);
            pre();
            total_cnt++;
            if (in_ready !== one) $display("FAIL contention_grant k=%0d got=%b exp=%b", k, in_ready, one);
            else pass_cnt++;
            post();
            total_cnt++;
            if (out_valid[4] !== 1'b1 || out_data[4*F +: F] !== e)
                $display("FAIL contention_out k=%0d got=%b/%h exp=1/%h", k, out_valid[4], out_data[4*F +: F], e);
            else pass_cnt++;
        end
        clear_in();
        pre();
        post();
    endtask

    task automatic test_wormhole();
        logic [F-1:0] e;
        do_reset();
        set_in(2, 1'b1, 16'hC000, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            e = F'(16'hB001 + k);
            set_in(1, 1'b1, e, 0, k == 2);
            pre();
            total_cnt++;
            if (in_ready[2:1] !== 2'b01) $display("FAIL wormhole_block k=%0d got=%b exp=01", k, in_ready[2:1]);
            else pass_cnt++;
            post();
            total_cnt++;
            if (out_data[F-1:0] !== e) $display("FAIL wormhole_flit k=%0d got=%h exp=%h", k, out_data[F-1:0], e);
            else pass_cnt++;
        end
        set_in(1, 1'b0, 16'h0, 0, 1'b0);
        pre();
        total_cnt++;
        if (in_ready[2] !== 1'b1) $display("FAIL wormhole_release got=%b exp=1", in_ready[2]); else pass_cnt++;
        post();
        total_cnt++;
        if (out_data[F-1:0] !== 16'hC000) $display("FAIL wormhole_next got=%h exp=c000", out_data[F-1:0]);
        else pass_cnt++;
        clear_in();
        pre();
        post();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready[2] = 1'b0;
        set_in(0, 1'b1, 16'h1234, 2, 1'b0);
        pre();
        post();
        total_cnt++;
        if (out_valid[2] !== 1'b1 || out_data[2*F +: F] !== 16'h1234)
            $display("FAIL bp_first got=%b/%h exp=1/1234", out_valid[2], out_data[2*F +: F]);
        else pass_cnt++;
        set_in(0, 1'b1, 16'h5678, 2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            pre();
            total_cnt++;
            if (in_ready[0] !== 1'b0) $display("FAIL bp_stall_ready k=%0d got=%b exp=0", k, in_ready[0]);
            else pass_cnt++;
            post();
            total_cnt++;
            if (out_data[2*F +: F] !== 16'h1234) $display("FAIL bp_hold k=%0d got=%h exp=1234", k, out_data[2*F +: F]);
            else pass_cnt++;
        end
        out_ready[2] = 1'b1;
        pre();
        total_cnt++;
        if (in_ready[0] !== 1'b1) $display("FAIL bp_resume_ready got=%b exp=1", in_ready[0]); else pass_cnt++;
        post();
        total_cnt++;
        if (out_data[2*F +: F] !== 16'h5678) $display("FAIL bp_second got=%h exp=5678", out_data[2*F +: F]);
        else pass_cnt++;
        clear_in();
        pre();
        post();
    endtask

    task automatic test_parallel_err();
        do_reset();
        set_in(0, 1'b1, 16'h0A03, 3, 1'b1);
        set_in(3, 1'b1, 16'h3A00, 0, 1'b1);
        set_in(4, 1'b1, 16'h4E4E, 7, 1'b1);
        pre();
        total_cnt++;
        if (in_ready !== 5'b11001) $display("FAIL par_ready got=%b exp=11001", in_ready); else pass_cnt++;
        post();
        total_cnt++;
        if (out_valid !== 5'b01001 || out_data[3*F +: F] !== 16'h0A03 || out_data[F-1:0] !== 16'h3A00)
            $display("FAIL par_out got=%b/%h/%h exp=01001/0a03/3a00", out_valid, out_data[3*F +: F], out_data[F-1:0]);
        else pass_cnt++;
        total_cnt++;
        if (dest_err !== 5'b10000) $display("FAIL par_dest_err got=%b exp=10000", dest_err); else pass_cnt++;
        clear_in();
        set_in(4, 1'b1, 16'h4E4F, 7, 1'b1);
        pre();
        post();
        total_cnt++;
        if (out_valid !== '0 || dest_err !== 5'b10000)
            $display("FAIL err_only got=%b/%b exp=00000/10000", out_valid, dest_err);
        else pass_cnt++;
        clear_in();
        pre();
        post();
        total_cnt++;
        if (dest_err !== '0) $display("FAIL err_pulse got=%b exp=0", dest_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_in(1, 1'b1, F'(16'hD001 + k), 2, 1'b0);
            pre();
            post();
        end
        set_in(1, 1'b1, 16'hD003, 2, 1'b0);
        RST = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== '0 || in_ready !== '0 || out_data !== '0)
            $display("FAIL rmid_abort got=%b/%b/%h exp=0/0/0", out_valid, in_ready, out_data);
        else pass_cnt++;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        model_reset();
        clear_in();
        set_in(3, 1'b1, 16'hE003, 2, 1'b1);
        pre();
        total_cnt++;
        if (in_ready !== 5'b01000) $display("FAIL rmid_regrant got=%b exp=01000", in_ready); else pass_cnt++;
        post();
        total_cnt++;
        if (out_valid[2] !== 1'b1 || out_data[2*F +: F] !== 16'hE003)
            $display("FAIL rmid_out got=%b/%h exp=1/e003", out_valid[2], out_data[2*F +: F]);
        else pass_cnt++;
        clear_in();
        pre();
        post();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                set_in(i, ($urandom % 10) < 6, F'($urandom),
                       (($urandom % 10) < 8) ? int'($urandom % 5) : 5 + int'($urandom % 3),
                       ($urandom % 3) == 0);
                out_ready[i] = ($urandom % 10) < 7;
            end
            pre();
            post();
        end
        clear_in();
        out_ready = '1;
        pre();
        post();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wormhole();
        test_backpressure();
        test_parallel_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
